// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline hazard/interlock
//               controller: mul/div sequencer state encoding, stall-cause
//               codes, default unit latencies and a latency select helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Mul/div sequencer states (explicit one-bit encoding)
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // stall_cause encodings
    localparam logic [1:0] SC_NONE    = 2'b00;
    localparam logic [1:0] SC_LOADUSE = 2'b01;
    localparam logic [1:0] SC_MDBUSY  = 2'b10;

    // Default execution-unit latencies in cycles
    localparam int unsigned c_mul_cycles = 4;
    localparam int unsigned c_div_cycles = 32;

    // Latency of the operation selected by the ID-stage divide qualifier
    function automatic int unsigned md_latency(
        input logic        is_div,
        input int unsigned mul_cycles,
        input int unsigned div_cycles
    );
        return is_div ? div_cycles : mul_cycles;
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_seq.sv
`default_nettype none
// ============================================================================
// Module      : md_seq
// Description : Multiply/divide sequencer. Two-state FSM with a down-counting
//               latency counter. Accepts a start pulse, stays busy for the
//               selected latency and strobes the HI/LO write in its last
//               busy cycle.
// Ports       : clock, reset   - clock / synchronous active-high reset
//               md_start       - start pulse (already qualified by no-stall)
//               id_div         - 1 = divide latency, 0 = multiply latency
//               md_busy        - operation in flight (incl. write cycle)
//               hilo_we        - one-cycle HI/LO write strobe
// Revision    : 1.0 - initial release
// ============================================================================
module md_seq
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = c_mul_cycles,
    parameter int unsigned DIV_CYCLES = c_div_cycles,
    parameter int unsigned CW         = $clog2(DIV_CYCLES)
) (
    input  logic clock,
    input  logic reset,
    input  logic md_start,
    input  logic id_div,
    output logic md_busy,
    output logic hilo_we
);

    md_state_t     r_state;
    md_state_t     w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_hilo_we;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_hilo_we   = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (md_start) begin
                    // Loaded with L-1 so busy lasts exactly L cycles
                    w_cnt_nxt   = CW'(md_latency(id_div, MUL_CYCLES, DIV_CYCLES) - 1);
                    w_state_nxt = MD_BUSY;
                end
            end
            MD_BUSY: begin
                if (r_cnt == '0) begin
                    w_hilo_we   = 1'b1;
                    w_state_nxt = MD_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CW'(1);
                end
            end
            default: begin
                w_state_nxt = MD_IDLE;
            end
        endcase
    end

    assign md_busy = (r_state == MD_BUSY);
    assign hilo_we = w_hilo_we;

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Central interlock controller for the five-stage pipeline.
//               Detects load-use and mul/div-busy hazards, drives the PC and
//               IF/ID write enable, ID/EX bubble and IF/ID flush, launches
//               the mul/div sequencer and keeps a saturating stall counter.
// Ports       : clock, reset            - clock / sync active-high reset
//               id_rs, id_rt            - ID source register numbers
//               id_use_rs, id_use_rt    - ID instruction reads rs / rt
//               id_muldiv, id_div       - ID is mult/div; 1 = divide
//               id_hilo_rd              - ID is mfhi/mflo
//               id_br_taken             - ID branch/jump resolved taken
//               ewreg, em2reg, ern      - EX write / load / destination
//               wpcir, bubble           - PC+IF/ID enable, ID/EX bubble
//               flush_ifid              - IF/ID flush after taken branch
//               md_start, md_busy       - mul/div launch / in flight
//               hilo_we                 - HI/LO write strobe
//               stall_cause             - 00 none, 01 load-use, 10 mul/div
//               stall_cycles            - saturating stalled-cycle count
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MUL_CYCLES = c_mul_cycles,
    parameter int unsigned DIV_CYCLES = c_div_cycles,
    parameter int unsigned CW         = $clog2(DIV_CYCLES)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic        id_muldiv,
    input  logic        id_div,
    input  logic        id_hilo_rd,
    input  logic        id_br_taken,
    input  logic        ewreg,
    input  logic        em2reg,
    input  logic [4:0]  ern,
    output logic        wpcir,
    output logic        bubble,
    output logic        flush_ifid,
    output logic        md_start,
    output logic        md_busy,
    output logic        hilo_we,
    output logic [1:0]  stall_cause,
    output logic [15:0] stall_cycles
);

    localparam logic [15:0] c_stall_max = 16'hFFFF;

    logic        w_load_use;
    logic        w_md_hazard;
    logic        w_stall;
    logic        w_md_start;
    logic        w_md_busy;
    logic [15:0] r_stall_cycles;

    // A load in EX cannot forward to ID in time; r0 is never a real hazard
    assign w_load_use = ewreg & em2reg & (ern != 5'd0) &
                        (((ern == id_rs) & id_use_rs) | ((ern == id_rt) & id_use_rt));

    // A new mul/div or HI/LO read must wait until the pending result is written
    assign w_md_hazard = w_md_busy & (id_muldiv | id_hilo_rd);

    assign w_stall = w_load_use | w_md_hazard;

    // Branch operands are not valid while stalled, so the flush is suppressed
    assign wpcir      = ~w_stall;
    assign bubble     = w_stall;
    assign flush_ifid = ~w_stall & id_br_taken;
    assign w_md_start = ~w_stall & id_muldiv;
    assign md_start   = w_md_start;

    always_comb begin
        stall_cause = SC_NONE;
        if (w_load_use) begin
            stall_cause = SC_LOADUSE;
        end else if (w_md_hazard) begin
            stall_cause = SC_MDBUSY;
        end
    end

    md_seq #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES),
        .CW         (CW)
    ) u_md_seq (
        .clock    (clock),
        .reset    (reset),
        .md_start (w_md_start),
        .id_div   (id_div),
        .md_busy  (w_md_busy),
        .hilo_we  (hilo_we)
    );

    assign md_busy = w_md_busy;

    // One increment per stalled cycle regardless of how many hazards coincide
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stall_cycles <= '0;
        end else if (w_stall && (r_stall_cycles != c_stall_max)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl. A behavioural model
//               (remaining-busy-cycles count and integer stall tally) is
//               compared with the DUT on every cycle; directed scenarios add
//               literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int MUL_L = 4;
    localparam int DIV_L = 32;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ern;
    logic        id_use_rs, id_use_rt, id_muldiv, id_div, id_hilo_rd, id_br_taken;
    logic        ewreg, em2reg;
    logic        wpcir, bubble, flush_ifid, md_start, md_busy, hilo_we;
    logic [1:0]  stall_cause;
    logic [15:0] stall_cycles;

    int errors = 0;
    int checks = 0;
    bit check_en = 1'b0;

    // Model state: cycles of busy still to come (including the current one)
    int m_rem = 0;
    int m_cnt = 0;

    pipe_hazard_ctrl #(
        .MUL_CYCLES (MUL_L),
        .DIV_CYCLES (DIV_L)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_muldiv    (id_muldiv),
        .id_div       (id_div),
        .id_hilo_rd   (id_hilo_rd),
        .id_br_taken  (id_br_taken),
        .ewreg        (ewreg),
        .em2reg       (em2reg),
        .ern          (ern),
        .wpcir        (wpcir),
        .bubble       (bubble),
        .flush_ifid   (flush_ifid),
        .md_start     (md_start),
        .md_busy      (md_busy),
        .hilo_we      (hilo_we),
        .stall_cause  (stall_cause),
        .stall_cycles (stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit f_load_use();
        return ewreg && em2reg && (ern != 0) &&
               (((ern == id_rs) && id_use_rs) || ((ern == id_rt) && id_use_rt));
    endfunction

    function automatic bit f_md_hazard();
        return (m_rem > 0) && (id_muldiv || id_hilo_rd);
    endfunction

    function automatic bit f_stall();
        return f_load_use() || f_md_hazard();
    endfunction

    // Model advance at the active edge
    always @(posedge clock) begin
        if (reset) begin
            m_rem <= 0;
            m_cnt <= 0;
        end else begin
            if (m_rem > 0)
                m_rem <= m_rem - 1;
            else if (!f_stall() && id_muldiv)
                m_rem <= id_div ? DIV_L : MUL_L;
            if (f_stall())
                m_cnt <= (m_cnt < 65535) ? m_cnt + 1 : 65535;
        end
    end

    // Every-cycle comparison, away from the active edge
    always @(negedge clock) begin
        if (check_en) begin
            bit st;
            int cause;
            st    = f_stall();
            cause = f_load_use() ? 1 : (f_md_hazard() ? 2 : 0);
            chk("wpcir",        int'(wpcir),        int'(!st));
            chk("bubble",       int'(bubble),       int'(st));
            chk("flush_ifid",   int'(flush_ifid),   int'(!st && id_br_taken));
            chk("md_start",     int'(md_start),     int'(!st && id_muldiv));
            chk("md_busy",      int'(md_busy),      int'(m_rem > 0));
            chk("hilo_we",      int'(hilo_we),      int'(m_rem == 1));
            chk("stall_cause",  int'(stall_cause),  cause);
            chk("stall_cycles", int'(stall_cycles), m_cnt);
        end
    end

    task automatic idle();
        id_rs = 0; id_rt = 0; ern = 0;
        id_use_rs = 0; id_use_rt = 0; id_muldiv = 0; id_div = 0;
        id_hilo_rd = 0; id_br_taken = 0; ewreg = 0; em2reg = 0;
    endtask

    task automatic set_load_use();
        ewreg = 1; em2reg = 1; ern = 5'd8; id_rs = 5'd8; id_use_rs = 1;
    endtask

    // Wait to the sampling point of the current cycle
    task automatic sample();
        @(negedge clock);
    endtask

    // Move to the next cycle (inputs may be changed after this returns)
    task automatic next();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int starts, hilos, sc_first, sc_second;
        idle();
        reset = 1;
        next();
        check_en = 1'b1;
        next();
        reset = 0;

        // Reset values
        sample();
        chk("rst_wpcir", int'(wpcir), 1);
        chk("rst_bubble", int'(bubble), 0);
        chk("rst_busy", int'(md_busy), 0);
        chk("rst_cause", int'(stall_cause), 0);
        chk("rst_cycles", int'(stall_cycles), 0);
        next();

        // Load-use on rs
        set_load_use();
        sample();
        chk("lu_wpcir", int'(wpcir), 0);
        chk("lu_bubble", int'(bubble), 1);
        chk("lu_cause", int'(stall_cause), 1);
        next();
        idle();
        sample();
        chk("lu_cycles", int'(stall_cycles), 1);
        chk("lu_over", int'(wpcir), 1);
        next();
        set_load_use(); ern = 0; id_rs = 0;
        sample();
        chk("lu_r0", int'(wpcir), 1);
        next();
        set_load_use(); id_use_rs = 0;
        sample();
        chk("lu_nouse", int'(wpcir), 1);
        next();
        idle();

        // mult at cycle 0, mfhi in cycles 1..5
        id_muldiv = 1;
        sample();
        chk("mul_start", int'(md_start), 1);
        next();
        idle();
        id_hilo_rd = 1;
        for (int k = 1; k <= 4; k++) begin
            sample();
            chk("mul_busy", int'(md_busy), 1);
            chk("mul_hilo", int'(hilo_we), int'(k == 4));
            chk("mfhi_cause", int'(stall_cause), 2);
            next();
        end
        sample();
        chk("mfhi_go", int'(wpcir), 1);
        chk("mul_done", int'(md_busy), 0);
        next();
        idle();

        // Back-to-back divides
        starts = 0; hilos = 0; sc_first = 0; sc_second = 0;
        id_muldiv = 1; id_div = 1;
        for (int k = 0; k < 2 * (DIV_L + 1); k++) begin
            sample();
            if (md_start) begin
                if (starts == 0) sc_first = int'(stall_cycles);
                else sc_second = int'(stall_cycles);
                starts++;
            end
            if (hilo_we) hilos++;
            next();
        end
        idle();
        chk("div_starts", starts, 2);
        chk("div_hilos", hilos, 2);
        chk("div_gap", sc_second - sc_first, DIV_L);

        // Taken branch blocked by a load-use stall, then allowed
        set_load_use(); id_br_taken = 1;
        sample();
        chk("br_lu_flush", int'(flush_ifid), 0);
        chk("br_lu_bubble", int'(bubble), 1);
        next();
        idle(); id_br_taken = 1;
        sample();
        chk("br_flush", int'(flush_ifid), 1);
        chk("br_wpcir", int'(wpcir), 1);
        next();
        idle();

        // Reset in cycle 10 of a divide
        id_muldiv = 1; id_div = 1;
        next();
        idle();
        for (int k = 1; k < 10; k++) next();
        reset = 1;
        next();
        reset = 0;
        sample();
        chk("rstdiv_busy", int'(md_busy), 0);
        chk("rstdiv_cycles", int'(stall_cycles), 0);
        hilos = 0;
        for (int k = 0; k < DIV_L + 4; k++) begin
            sample();
            if (hilo_we) hilos++;
            next();
        end
        chk("rstdiv_hilo", hilos, 0);

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            reset       = ($urandom_range(0, 199) == 0);
            id_rs       = 5'($urandom_range(0, 3));
            id_rt       = 5'($urandom_range(0, 3));
            ern         = 5'($urandom_range(0, 3));
            id_use_rs   = 1'($urandom);
            id_use_rt   = 1'($urandom);
            ewreg       = 1'($urandom);
            em2reg      = 1'($urandom);
            id_muldiv   = ($urandom_range(0, 7) == 0);
            id_div      = ($urandom_range(0, 3) == 0);
            id_hilo_rd  = ($urandom_range(0, 5) == 0);
            id_br_taken = 1'($urandom);
            next();
        end
        reset = 1;
        idle();
        next();
        reset = 0;

        // Continuous stall: counter must saturate
        set_load_use();
        for (int k = 0; k < 70000; k++) next();
        sample();
        chk("sat_cycles", int'(stall_cycles), 16'hFFFF);
        next();
        idle();
        next();

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
